// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, frame-total helper and colour-bar lookup
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic logic [15:0] bar_field(input logic on, input int w);
    return on ? 16'((32'd1 << w) - 32'd1) : 16'd0;
  endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH x WIDTH shift register with async clear to RST_VAL (DEPTH 0 = wire)
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = vga_clk ^ clrn;
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    // shift one stage per clock, cleared to the idle pattern
    always_ff @(posedge vga_clk or negedge clrn)
      if (!clrn) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe: VGA timing + pixel-fetch pipeline, outputs aligned at RD_LAT+2; VGA_TEST_PATTERN_EN adds test_en colour bars
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int RD_LAT   = 1,
  parameter int SCALE    = 1,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  localparam int PIX_W   = R_W + G_W + B_W
) (
  input  logic             vga_clk,
  input  logic             clrn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  input  logic [PIX_W-1:0] d_in,
  output logic [ROW_W-1:0] row_addr,
  output logic [COL_W-1:0] col_addr,
  output logic             rdn,
  output logic [R_W-1:0]   r,
  output logic [G_W-1:0]   g,
  output logic [B_W-1:0]   b,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HA0 = H_SYNC + H_BP;
  localparam int VA0 = V_SYNC + V_BP;
  localparam logic HS_IDLE = ~HS_POL;
  localparam logic VS_IDLE = ~VS_POL;
`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = 6;
  localparam logic [DW-1:0] D_IDLE = {HS_IDLE, VS_IDLE, 1'b0, 3'b000};
`else
  localparam int DW = 3;
  localparam logic [DW-1:0] D_IDLE = {HS_IDLE, VS_IDLE, 1'b0};
`endif
  if (!(SCALE == 1 || SCALE == 2) || RD_LAT < 0 || RD_LAT > 4 || H_ACTIVE / SCALE > 2 ** COL_W || COL_W < 3) begin : g_bad_params
    $error("vga_timing_pipe: illegal SCALE/RD_LAT/COL_W");
  end
  logic [HW-1:0] h_count, h_off;
  logic [VW-1:0] v_count, v_off;
  logic h_last, v_last, h_act, v_act, vid, tp;
  logic hs1, vs1, de1, hs_d, vs_d, de_d;
  logic [DW-1:0] dly_d, dly_q;
  logic [R_W-1:0] r_n;
  logic [G_W-1:0] g_n;
  logic [B_W-1:0] b_n;
  assign h_last = int'(h_count) == H_TOTAL - 1;
  assign v_last = int'(v_count) == V_TOTAL - 1;
  assign h_act  = int'(h_count) >= HA0 && int'(h_count) < HA0 + H_ACTIVE;
  assign v_act  = int'(v_count) >= VA0 && int'(v_count) < VA0 + V_ACTIVE;
  assign vid    = h_act & v_act;
  assign h_off  = h_count - HW'(HA0);
  assign v_off  = v_count - VW'(VA0);
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_d;
  assign tp = test_en;
  assign dly_d = {hs1, vs1, de1, col_addr[COL_W-1 -: 3]};
  assign {hs_d, vs_d, de_d, bar_d} = dly_q;
`else
  assign tp = 1'b0;
  assign dly_d = {hs1, vs1, de1};
  assign {hs_d, vs_d, de_d} = dly_q;
`endif
  // free-running line and frame counters
  always_ff @(posedge vga_clk or negedge clrn)
    if (!clrn) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= h_last ? '0 : h_count + 1'b1;
      if (h_last) v_count <= v_last ? '0 : v_count + 1'b1;
    end
  // stage 1: RAM address/strobe, raw syncs and the undelayed wrap pulses
  always_ff @(posedge vga_clk or negedge clrn)
    if (!clrn) begin
      col_addr    <= '0;
      row_addr    <= '0;
      rdn         <= 1'b1;
      hs1         <= HS_IDLE;
      vs1         <= VS_IDLE;
      de1         <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      col_addr    <= COL_W'(h_off / HW'(SCALE));
      row_addr    <= ROW_W'(v_off / VW'(SCALE));
      rdn         <= ~(vid & ~tp);
      hs1         <= int'(h_count) < H_SYNC ? HS_POL : HS_IDLE;
      vs1         <= int'(v_count) < V_SYNC ? VS_POL : VS_IDLE;
      de1         <= vid;
      line_start  <= h_last;
      frame_start <= h_last & v_last;
    end
  vga_sync_delay #(.DEPTH(RD_LAT), .WIDTH(DW), .RST_VAL(D_IDLE)) u_dly (
    .vga_clk(vga_clk),
    .clrn   (clrn),
    .d      (dly_d),
    .q      (dly_q)
  );
  // colour select: RAM pixel (or bar pattern) while active, black otherwise
  always_comb begin
    r_n = de_d ? d_in[PIX_W-1 -: R_W] : '0;
    g_n = de_d ? d_in[G_W+B_W-1 -: G_W] : '0;
    b_n = de_d ? d_in[B_W-1:0] : '0;
`ifdef VGA_TEST_PATTERN_EN
    r_n = (de_d && test_en) ? R_W'(bar_field(bar_d[2], R_W)) : r_n;
    g_n = (de_d && test_en) ? G_W'(bar_field(bar_d[1], G_W)) : g_n;
    b_n = (de_d && test_en) ? B_W'(bar_field(bar_d[0], B_W)) : b_n;
`endif
  end
  // output stage: colour registered together with the delayed syncs
  always_ff @(posedge vga_clk or negedge clrn)
    if (!clrn) begin
      hs <= HS_IDLE;
      vs <= VS_IDLE;
      de <= 1'b0;
      r  <= '0;
      g  <= '0;
      b  <= '0;
    end else begin
      hs <= hs_d;
      vs <= vs_d;
      de <= de_d;
      r  <= r_n;
      g  <= g_n;
      b  <= b_n;
    end
endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb_vga_timing_pipe: scoreboard bench for default, RD_LAT=3 and SCALE=2 instances
module tb_vga_timing_pipe;
  localparam int S_HACT = 16, S_HFP = 2, S_HSYNC = 4, S_HBP = 3, S_HT = 25, S_HA0 = 7;
  localparam int S_VACT = 6, S_VFP = 1, S_VSYNC = 2, S_VBP = 2, S_VT = 11, S_VA0 = 4;
  typedef struct packed {
    logic hs, vs, de, rdn, ls, fs;
    logic [3:0] col;
    logic [2:0] row;
    logic [2:0] r, g;
    logic [1:0] b;
  } exp_t;
  localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, default: '0};
  logic vga_clk = 1'b0;
  logic clrn = 1'b0;
  logic test_en = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  always #5 vga_clk = ~vga_clk;
  logic [7:0] d_def, d_l3, d_s2;
  logic [8:0] row_def;
  logic [9:0] col_def;
  logic [2:0] row_l3, row_s2, r_def, g_def, r_l3, g_l3, r_s2, g_s2;
  logic [3:0] col_l3, col_s2;
  logic [1:0] b_def, b_l3, b_s2;
  logic rdn_def, hs_def, vs_def, de_def, ls_def, fs_def;
  logic rdn_l3, hs_l3, vs_l3, de_l3, ls_l3, fs_l3;
  logic rdn_s2, hs_s2, vs_s2, de_s2, ls_s2, fs_s2;
  logic [7:0] l3_p [3];
  vga_timing_pipe u_def (
    .vga_clk(vga_clk), .clrn(clrn),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .d_in(d_def), .row_addr(row_def), .col_addr(col_def), .rdn(rdn_def),
    .r(r_def), .g(g_def), .b(b_def), .hs(hs_def), .vs(vs_def), .de(de_def),
    .line_start(ls_def), .frame_start(fs_def)
  );
  vga_timing_pipe #(.H_ACTIVE(S_HACT), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_ACTIVE(S_VACT), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .RD_LAT(3), .SCALE(1), .COL_W(4), .ROW_W(3)) u_l3 (
    .vga_clk(vga_clk), .clrn(clrn),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .d_in(d_l3), .row_addr(row_l3), .col_addr(col_l3), .rdn(rdn_l3),
    .r(r_l3), .g(g_l3), .b(b_l3), .hs(hs_l3), .vs(vs_l3), .de(de_l3),
    .line_start(ls_l3), .frame_start(fs_l3)
  );
  vga_timing_pipe #(.H_ACTIVE(S_HACT), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_ACTIVE(S_VACT), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .RD_LAT(0), .SCALE(2), .COL_W(4), .ROW_W(3)) u_s2 (
    .vga_clk(vga_clk), .clrn(clrn),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .d_in(d_s2), .row_addr(row_s2), .col_addr(col_s2), .rdn(rdn_s2),
    .r(r_s2), .g(g_s2), .b(b_s2), .hs(hs_s2), .vs(vs_s2), .de(de_s2),
    .line_start(ls_s2), .frame_start(fs_s2)
  );
  // pixel RAM models: data = {col[2:0], row[2:0], 2'b01} after RD_LAT clocks
  always @(posedge vga_clk) begin
    d_def <= {col_def[2:0], row_def[2:0], 2'b01};
    l3_p[0] <= {col_l3[2:0], row_l3[2:0], 2'b01};
    l3_p[1] <= l3_p[0];
    l3_p[2] <= l3_p[1];
  end
  assign d_l3 = l3_p[2];
  assign d_s2 = {col_s2[2:0], row_s2[2:0], 2'b01};
  function automatic exp_t small_model(input int m, input int scale, input bit tp);
    int hh, vv;
    exp_t e;
    logic [2:0] bar;
    hh = m % S_HT;
    vv = (m / S_HT) % S_VT;
    e = '0;
    e.hs = !(hh < S_HSYNC);
    e.vs = !(vv < S_VSYNC);
    e.de = hh >= S_HA0 && hh < S_HA0 + S_HACT && vv >= S_VA0 && vv < S_VA0 + S_VACT;
    e.rdn = !(e.de && !tp);
    e.ls = hh == S_HT - 1;
    e.fs = e.ls && vv == S_VT - 1;
    e.col = 4'((hh - S_HA0) / scale);
    e.row = 3'((vv - S_VA0) / scale);
    bar = e.col[3:1];
    if (e.de && tp) begin
      e.r = bar[2] ? 3'h7 : 3'h0;
      e.g = bar[1] ? 3'h7 : 3'h0;
      e.b = bar[0] ? 2'h3 : 2'h0;
    end else if (e.de) begin
      e.r = e.col[2:0];
      e.g = e.row;
      e.b = 2'b01;
    end
    return e;
  endfunction
  task automatic reset_all;
    clrn = 1'b0;
    repeat (2) @(negedge vga_clk);
    clrn = 1'b1;
    cyc = 0;
  endtask
  task automatic test_reset;
    clrn = 1'b0;
    repeat (5) @(negedge vga_clk);
    total++;
    if ({rdn_def, hs_def, vs_def, de_def, ls_def, fs_def, r_def, g_def, b_def} !== {6'b111000, 8'h00}) begin
      bad++;
      $display("FAIL reset_def got=%b exp=%b", {rdn_def, hs_def, vs_def, de_def, ls_def, fs_def, r_def, g_def, b_def}, {6'b111000, 8'h00});
    end
    total++;
    if ({row_def, col_def} !== 19'd0) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=0", {row_def, col_def});
    end
    total++;
    if ({rdn_l3, hs_l3, vs_l3, de_l3, r_l3, g_l3, b_l3, rdn_s2, hs_s2, vs_s2, de_s2} !== {4'b1110, 8'h00, 4'b1110}) begin
      bad++;
      $display("FAIL reset_small got=%b exp=%b", {rdn_l3, hs_l3, vs_l3, de_l3, r_l3, g_l3, b_l3, rdn_s2, hs_s2, vs_s2, de_s2}, {4'b1110, 8'h00, 4'b1110});
    end
    clrn = 1'b1;
    cyc = 0;
  endtask
  task automatic test_default_timing;
    int hs_low = 0, ls_cnt = 0, first_ls = 0, rdn_low = 0;
    while (cyc < 1600) begin
      @(negedge vga_clk);
      cyc++;
      if (cyc > 800 && !hs_def) hs_low++;
      if (!rdn_def) rdn_low++;
      if (ls_def) begin
        ls_cnt++;
        if (first_ls == 0) first_ls = cyc;
      end
    end
    total++;
    if (hs_low !== 96) begin bad++; $display("FAIL hs_low_per_line got=%0d exp=96", hs_low); end
    total++;
    if (ls_cnt !== 2) begin bad++; $display("FAIL line_start_count got=%0d exp=2", ls_cnt); end
    total++;
    if (first_ls !== 800) begin bad++; $display("FAIL line_start_pos got=%0d exp=800", first_ls); end
    total++;
    if (rdn_low !== 0) begin bad++; $display("FAIL rdn_blanking got=%0d exp=0", rdn_low); end
  endtask
  task automatic test_first_pixel;
    int early_de = 0, first_rdn = 0;
    while (cyc < 28146) begin
      @(negedge vga_clk);
      cyc++;
      if (de_def) early_de++;
      if (!rdn_def && first_rdn == 0) first_rdn = cyc;
    end
    total++;
    if (early_de !== 0) begin bad++; $display("FAIL de_before_active got=%0d exp=0", early_de); end
    total++;
    if (first_rdn !== 28145) begin bad++; $display("FAIL first_rdn got=%0d exp=28145", first_rdn); end
    @(negedge vga_clk);
    cyc++;
    total++;
    if ({de_def, r_def, g_def, b_def} !== {1'b1, 3'd0, 3'd0, 2'd1}) begin
      bad++;
      $display("FAIL first_pixel got=%b exp=%b", {de_def, r_def, g_def, b_def}, {1'b1, 3'd0, 3'd0, 2'd1});
    end
    @(negedge vga_clk);
    cyc++;
    total++;
    if ({de_def, r_def, g_def, b_def} !== {1'b1, 3'd1, 3'd0, 2'd1}) begin
      bad++;
      $display("FAIL second_pixel got=%b exp=%b", {de_def, r_def, g_def, b_def}, {1'b1, 3'd1, 3'd0, 2'd1});
    end
  endtask
  task automatic test_midline_reset;
    int first_hs = 0, first_ls = 0;
    while (cyc < 28400) begin
      @(negedge vga_clk);
      cyc++;
    end
    total++;
    if ({de_def, rdn_def} !== 2'b10) begin bad++; $display("FAIL pre_reset_active got=%b exp=10", {de_def, rdn_def}); end
    clrn = 1'b0;
    #1;
    total++;
    if ({rdn_def, hs_def, vs_def, de_def, ls_def, fs_def, r_def, g_def, b_def, row_def, col_def} !== {6'b111000, 8'h00, 19'd0}) begin
      bad++;
      $display("FAIL midline_reset got=%b exp=%b", {rdn_def, hs_def, vs_def, de_def, ls_def, fs_def, r_def, g_def, b_def, row_def, col_def}, {6'b111000, 8'h00, 19'd0});
    end
    @(negedge vga_clk);
    clrn = 1'b1;
    cyc = 0;
    while (cyc < 800) begin
      @(negedge vga_clk);
      cyc++;
      if (!hs_def && first_hs == 0) first_hs = cyc;
      if (ls_def && first_ls == 0) first_ls = cyc;
    end
    total++;
    if (first_hs !== 3) begin bad++; $display("FAIL restart_hs got=%0d exp=3", first_hs); end
    total++;
    if (first_ls !== 800) begin bad++; $display("FAIL restart_line_start got=%0d exp=800", first_ls); end
  endtask
  task automatic test_pixels_lat3;
    exp_t sb[$];
    exp_t e, o;
    int first_de = 0;
    logic [7:0] first_rgb = '0;
    reset_all();
    repeat (4) sb.push_back(IDLE);
    while (cyc < 600) begin
      @(negedge vga_clk);
      cyc++;
      e = small_model(cyc - 1, 1, 1'b0);
      total++;
      if ({rdn_l3, ls_l3, fs_l3} !== {e.rdn, e.ls, e.fs}) begin
        bad++;
        $display("FAIL l3_stage1 n=%0d got=%b exp=%b", cyc, {rdn_l3, ls_l3, fs_l3}, {e.rdn, e.ls, e.fs});
      end
      if (e.de) begin
        total++;
        if ({row_l3, col_l3} !== {e.row, e.col}) begin
          bad++;
          $display("FAIL l3_addr n=%0d got=%h exp=%h", cyc, {row_l3, col_l3}, {e.row, e.col});
        end
      end
      sb.push_back(e);
      o = sb.pop_front();
      total++;
      if ({hs_l3, vs_l3, de_l3, r_l3, g_l3, b_l3} !== {o.hs, o.vs, o.de, o.r, o.g, o.b}) begin
        bad++;
        $display("FAIL l3_out n=%0d got=%b exp=%b", cyc, {hs_l3, vs_l3, de_l3, r_l3, g_l3, b_l3}, {o.hs, o.vs, o.de, o.r, o.g, o.b});
      end
      if (de_l3 && first_de == 0) begin
        first_de = cyc;
        first_rgb = {r_l3, g_l3, b_l3};
      end
    end
    total++;
    if (first_de !== S_VA0 * S_HT + S_HA0 + 5) begin bad++; $display("FAIL l3_first_de got=%0d exp=%0d", first_de, S_VA0 * S_HT + S_HA0 + 5); end
    total++;
    if (first_rgb !== 8'b000_000_01) begin bad++; $display("FAIL l3_first_rgb got=%b exp=00000001", first_rgb); end
  endtask
  task automatic test_scale2;
    exp_t sb[$];
    exp_t e, o;
    int max_row = 0, vs_low = 0;
    reset_all();
    sb.push_back(IDLE);
    while (cyc < 600) begin
      @(negedge vga_clk);
      cyc++;
      e = small_model(cyc - 1, 2, 1'b0);
      if (cyc >= 2 && cyc <= 276 && !vs_s2) vs_low++;
      if (!rdn_s2 && int'(row_s2) > max_row) max_row = int'(row_s2);
      total++;
      if ({rdn_s2, ls_s2, fs_s2} !== {e.rdn, e.ls, e.fs}) begin
        bad++;
        $display("FAIL s2_stage1 n=%0d got=%b exp=%b", cyc, {rdn_s2, ls_s2, fs_s2}, {e.rdn, e.ls, e.fs});
      end
      if (e.de) begin
        total++;
        if ({row_s2, col_s2} !== {e.row, e.col}) begin
          bad++;
          $display("FAIL s2_addr n=%0d got=%h exp=%h", cyc, {row_s2, col_s2}, {e.row, e.col});
        end
      end
      sb.push_back(e);
      o = sb.pop_front();
      total++;
      if ({hs_s2, vs_s2, de_s2, r_s2, g_s2, b_s2} !== {o.hs, o.vs, o.de, o.r, o.g, o.b}) begin
        bad++;
        $display("FAIL s2_out n=%0d got=%b exp=%b", cyc, {hs_s2, vs_s2, de_s2, r_s2, g_s2, b_s2}, {o.hs, o.vs, o.de, o.r, o.g, o.b});
      end
    end
    total++;
    if (max_row !== S_VACT / 2 - 1) begin bad++; $display("FAIL s2_max_row got=%0d exp=%0d", max_row, S_VACT / 2 - 1); end
    total++;
    if (vs_low !== S_VSYNC * S_HT) begin bad++; $display("FAIL s2_vs_low got=%0d exp=%0d", vs_low, S_VSYNC * S_HT); end
  endtask
  task automatic test_wrap;
    int fs_cnt = 0, fs1 = 0, fs2 = 0, ls_with_fs = 0;
    reset_all();
    while (cyc < 560) begin
      @(negedge vga_clk);
      cyc++;
      if (fs_s2) begin
        fs_cnt++;
        if (ls_s2) ls_with_fs++;
        if (fs1 == 0) fs1 = cyc;
        else if (fs2 == 0) fs2 = cyc;
      end
    end
    total++;
    if (fs1 !== S_HT * S_VT) begin bad++; $display("FAIL wrap_first_fs got=%0d exp=%0d", fs1, S_HT * S_VT); end
    total++;
    if (fs2 - fs1 !== S_HT * S_VT) begin bad++; $display("FAIL wrap_fs_period got=%0d exp=%0d", fs2 - fs1, S_HT * S_VT); end
    total++;
    if (fs_cnt !== 2) begin bad++; $display("FAIL wrap_fs_count got=%0d exp=2", fs_cnt); end
    total++;
    if (ls_with_fs !== 2) begin bad++; $display("FAIL wrap_ls_with_fs got=%0d exp=2", ls_with_fs); end
  endtask
`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern;
    exp_t sb[$];
    exp_t e, o;
    int rdn_low = 0;
    test_en = 1'b1;
    reset_all();
    repeat (4) sb.push_back(IDLE);
    while (cyc < 300) begin
      @(negedge vga_clk);
      cyc++;
      if (!rdn_l3) rdn_low++;
      e = small_model(cyc - 1, 1, 1'b1);
      sb.push_back(e);
      o = sb.pop_front();
      total++;
      if ({hs_l3, vs_l3, de_l3, r_l3, g_l3, b_l3} !== {o.hs, o.vs, o.de, o.r, o.g, o.b}) begin
        bad++;
        $display("FAIL bars_out n=%0d got=%b exp=%b", cyc, {hs_l3, vs_l3, de_l3, r_l3, g_l3, b_l3}, {o.hs, o.vs, o.de, o.r, o.g, o.b});
      end
    end
    total++;
    if (rdn_low !== 0) begin bad++; $display("FAIL bars_rdn got=%0d exp=0", rdn_low); end
    test_en = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_default_timing();
    test_first_pixel();
    test_midline_reset();
    test_pixels_lat3();
    test_scale2();
    test_wrap();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
